// File: rtl/reel_stop_engine_pkg.sv
// Shared types and constants for the multi-reel spin/stop engine.
package reel_stop_engine_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSpin,
    StStopping,
    StDone
  } reel_state_e;

  localparam int unsigned VSTOP_W_DEF = 6;
  localparam int unsigned PSTOP_W_DEF = 5;

  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_POLY   = 16'hB400;
  localparam logic [15:0] SEED_SPREAD = 16'h1F35;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_seed(input logic [15:0] base, input int unsigned r);
    return base ^ 16'((r + 1) * SEED_SPREAD);
  endfunction

endpackage

// File: rtl/reel_stop_engine_if.sv
// Game-FSM / renderer facing bus of the reel stop engine.
// REEL_FORCE_STOP_EN adds force_en/force_vstop for deterministic stop selection.
interface reel_stop_engine_if #(
  parameter int unsigned NUM_REELS = 3,
  parameter int unsigned VSTOP_W   = 6,
  parameter int unsigned PSTOP_W   = 5
);
  localparam int unsigned CfgReelW = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;

  logic                         spin_req;
  logic                         stop_req;
  logic                         cfg_we;
  logic [CfgReelW-1:0]          cfg_reel;
  logic [VSTOP_W-1:0]           cfg_addr;
  logic [PSTOP_W-1:0]           cfg_data;
  logic                         cfg_err;
  logic                         busy;
  logic [NUM_REELS*PSTOP_W-1:0] reel_pos;
  logic [NUM_REELS-1:0]         reel_stopped;
  logic                         done;
`ifdef REEL_FORCE_STOP_EN
  logic                         force_en;
  logic [NUM_REELS*VSTOP_W-1:0] force_vstop;
`endif

  modport master (
    output spin_req, stop_req, cfg_we, cfg_reel, cfg_addr, cfg_data,
`ifdef REEL_FORCE_STOP_EN
    output force_en, force_vstop,
`endif
    input  cfg_err, busy, reel_pos, reel_stopped, done
  );

  modport slave (
    input  spin_req, stop_req, cfg_we, cfg_reel, cfg_addr, cfg_data,
`ifdef REEL_FORCE_STOP_EN
    input  force_en, force_vstop,
`endif
    output cfg_err, busy, reel_pos, reel_stopped, done
  );

endinterface

// File: rtl/reel_stop_engine_map_table.sv
// Per-reel virtual-to-physical stop map: identity after reset, sync write, comb read.
module reel_stop_engine_map_table #(
  parameter int unsigned VSTOP_W = 6,
  parameter int unsigned PSTOP_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [VSTOP_W-1:0] waddr,
  input  logic [PSTOP_W-1:0] wdata,
  input  logic [VSTOP_W-1:0] raddr,
  output logic [PSTOP_W-1:0] rdata
);
  localparam int unsigned Depth = 2 ** VSTOP_W;

  logic [PSTOP_W-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < Depth; v++) begin
        mem[v] <= PSTOP_W'(v);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/reel_stop_engine.sv
// Spin/stop sequencer for NUM_REELS reels with weighted stop maps and staggered stops.
// REEL_FORCE_STOP_EN lets force_vstop replace the LFSR stop source on the stop edge.
module reel_stop_engine
  import reel_stop_engine_pkg::*;
#(
  parameter int unsigned NUM_REELS = 3,
  parameter int unsigned VSTOP_W   = VSTOP_W_DEF,
  parameter int unsigned PSTOP_W   = PSTOP_W_DEF,
  parameter int unsigned STOP_GAP  = 16,
  parameter int unsigned SPIN_DIV  = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic              clk,
  input logic              rst_n,
  reel_stop_engine_if.slave bus
);
  localparam int unsigned CfgReelW = (NUM_REELS > 1) ? $clog2(NUM_REELS) : 1;
  localparam int unsigned DivW     = $clog2(SPIN_DIV + 1);
  localparam int unsigned GapW     = $clog2(NUM_REELS * STOP_GAP + 1);

  reel_state_e                  state_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         cfg_err_q;
  logic [NUM_REELS*PSTOP_W-1:0] reel_pos_q;
  logic [NUM_REELS-1:0]         reel_stopped_q;
  logic [DivW-1:0]              div_q;
  logic [GapW-1:0]              gap_q;
  logic [15:0]                  lfsr_q    [NUM_REELS];
  logic [VSTOP_W-1:0]           vstop_q   [NUM_REELS];
  logic [VSTOP_W-1:0]           vstop_src [NUM_REELS];
  logic [PSTOP_W-1:0]           map_rd    [NUM_REELS];
  logic [NUM_REELS-1:0]         map_we;
  logic                         cfg_ok;
  logic                         div_tick;

  assign cfg_ok   = bus.cfg_we && (state_q == StIdle) && (32'(bus.cfg_reel) < NUM_REELS);
  assign div_tick = (div_q == DivW'(SPIN_DIV - 1));

  for (genvar r = 0; r < NUM_REELS; r++) begin : g_reel
    assign map_we[r] = cfg_ok && (bus.cfg_reel == CfgReelW'(r));

`ifdef REEL_FORCE_STOP_EN
    assign vstop_src[r] = bus.force_en ? bus.force_vstop[r*VSTOP_W +: VSTOP_W]
                                       : lfsr_q[r][VSTOP_W-1:0];
`else
    assign vstop_src[r] = lfsr_q[r][VSTOP_W-1:0];
`endif

    reel_stop_engine_map_table #(
      .VSTOP_W(VSTOP_W),
      .PSTOP_W(PSTOP_W)
    ) u_map (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (map_we[r]),
      .waddr(bus.cfg_addr),
      .wdata(bus.cfg_data),
      .raddr(vstop_q[r]),
      .rdata(map_rd[r])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
      reel_pos_q     <= '0;
      reel_stopped_q <= '1;
      div_q          <= '0;
      gap_q          <= '0;
      for (int r = 0; r < NUM_REELS; r++) begin
        lfsr_q[r]  <= lfsr_seed(LFSR_SEED, r);
        vstop_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REELS; r++) begin
        lfsr_q[r] <= lfsr_step(lfsr_q[r]);
      end
      cfg_err_q <= bus.cfg_we && !cfg_ok;
      done_q    <= 1'b0;

      // Reel motion shared by SPIN and STOPPING; in SPIN no reel is stopped.
      if (state_q == StSpin || state_q == StStopping) begin
        div_q <= div_tick ? '0 : div_q + DivW'(1);
        for (int r = 0; r < NUM_REELS; r++) begin
          if (!reel_stopped_q[r]) begin
            if (state_q == StStopping && gap_q == GapW'((r + 1) * STOP_GAP - 1)) begin
              reel_pos_q[r*PSTOP_W +: PSTOP_W] <= map_rd[r];
              reel_stopped_q[r]                <= 1'b1;
            end else if (div_tick) begin
              reel_pos_q[r*PSTOP_W +: PSTOP_W] <= reel_pos_q[r*PSTOP_W +: PSTOP_W] + PSTOP_W'(1);
            end
          end
        end
      end

      unique case (state_q)
        StIdle: begin
          if (bus.spin_req) begin
            state_q        <= StSpin;
            reel_stopped_q <= '0;
            div_q          <= '0;
            busy_q         <= 1'b1;
          end
        end
        StSpin: begin
          if (bus.stop_req) begin
            state_q <= StStopping;
            gap_q   <= '0;
            for (int r = 0; r < NUM_REELS; r++) begin
              vstop_q[r] <= vstop_src[r];
            end
          end
        end
        StStopping: begin
          if (&reel_stopped_q) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + GapW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.reel_pos     = reel_pos_q;
  assign bus.reel_stopped = reel_stopped_q;

endmodule

// File: tb/tb_reel_stop_engine.sv
// Directed self-checking bench for reel_stop_engine (default or REEL_FORCE_STOP_EN build).
module tb_reel_stop_engine;
  localparam int unsigned NR  = 3;
  localparam int unsigned VW  = 6;
  localparam int unsigned PW  = 5;
  localparam int unsigned GAP = 16;
  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reel_stop_engine_if #(.NUM_REELS(NR), .VSTOP_W(VW), .PSTOP_W(PW)) bus ();

  reel_stop_engine #(
    .NUM_REELS(NR),
    .VSTOP_W  (VW),
    .PSTOP_W  (PW),
    .STOP_GAP (GAP),
    .SPIN_DIV (DIV),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0]   m_lfsr [NR];
  logic [PW-1:0] map_m  [NR][64];
  logic [VW-1:0] exp_v  [NR];

  // Reference LFSR, seeds precomputed by hand from 16'hACE1 ^ (r+1)*16'h1F35.
  always @(posedge clk) begin
    for (int r = 0; r < NR; r++) begin
      if (!rst_n) begin
        m_lfsr[r] <= (r == 0) ? 16'hB3D4 : (r == 1) ? 16'h928B : 16'hF17E;
      end else begin
        m_lfsr[r] <= {1'b0, m_lfsr[r][15:1]} ^ (m_lfsr[r][0] ? 16'hB400 : 16'h0000);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pos_of(input int r);
    return bus.reel_pos[r*PW +: PW];
  endfunction

  task automatic map_identity();
    for (int r = 0; r < NR; r++)
      for (int v = 0; v < 64; v++) map_m[r][v] = PW'(v);
  endtask

  // Called in SPIN just after a negedge; stop_req is accepted on the next edge T.
  task automatic stop_seq(input bit drop_wr, input bit spin_mid);
    logic [PW-1:0] exp_p [NR];
    for (int r = 0; r < NR; r++) begin
      exp_v[r] = m_lfsr[r][VW-1:0];
      exp_p[r] = map_m[r][exp_v[r]];
    end
    bus.stop_req = 1'b1;
    if (drop_wr) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_reel = 2'd0;
      bus.cfg_addr = exp_v[0];
      bus.cfg_data = ~exp_p[0];
    end
    tick();
    bus.stop_req = 1'b0;
    bus.cfg_we   = 1'b0;
    if (drop_wr) check("cfg_err_in_spin", 32'(bus.cfg_err), 32'd1);
    for (int k = 1; k <= 50; k++) begin
      if (spin_mid && k == 20) bus.spin_req = 1'b1;
      tick();
      bus.spin_req = 1'b0;
      if (drop_wr && k == 1) check("cfg_err_one_cycle", 32'(bus.cfg_err), 32'd0);
      for (int r = 0; r < NR; r++) begin
        if (k == (r + 1) * GAP - 1) check($sformatf("reel%0d_not_yet", r),
                                          32'(bus.reel_stopped[r]), 32'd0);
        if (k == (r + 1) * GAP) begin
          check($sformatf("reel%0d_stopped", r), 32'(bus.reel_stopped[r]), 32'd1);
          check($sformatf("reel%0d_pos", r), 32'(pos_of(r)), 32'(exp_p[r]));
        end
      end
      if (k == 48) begin
        check("busy_before_done", 32'(bus.busy), 32'd1);
        check("done_early", 32'(bus.done), 32'd0);
      end
      if (k == 49) begin
        check("done_pulse", 32'(bus.done), 32'd1);
        check("busy_drop", 32'(bus.busy), 32'd0);
      end
      if (k == 50) begin
        check("done_single", 32'(bus.done), 32'd0);
        check("stopped_held", 32'(bus.reel_stopped), 32'h7);
        check("pos_held", 32'(bus.reel_pos), 32'({exp_p[2], exp_p[1], exp_p[0]}));
      end
    end
  endtask

  initial begin
    int done_cnt;
    bus.spin_req = 1'b0;
    bus.stop_req = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_reel = '0;
    bus.cfg_addr = '0;
    bus.cfg_data = '0;
`ifdef REEL_FORCE_STOP_EN
    bus.force_en    = 1'b0;
    bus.force_vstop = '0;
`endif
    map_identity();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    check("rst_stopped", 32'(bus.reel_stopped), 32'h7);
    check("rst_pos", 32'(bus.reel_pos), 32'd0);

    // stop_req in IDLE is ignored
    bus.stop_req = 1'b1;
    tick();
    bus.stop_req = 1'b0;
    tick();
    check("idle_stop_busy", 32'(bus.busy), 32'd0);
    check("idle_stop_stopped", 32'(bus.reel_stopped), 32'h7);

    // Spin cadence and wrap
    bus.spin_req = 1'b1;
    tick();
    bus.spin_req = 1'b0;
    check("spin_busy", 32'(bus.busy), 32'd1);
    check("spin_unstopped", 32'(bus.reel_stopped), 32'd0);
    repeat (3) tick();
    check("cad_e3", 32'(pos_of(0)), 32'd0);
    tick();
    check("cad_e4", 32'(pos_of(0)), 32'd1);
    check("cad_e4_r2", 32'(pos_of(2)), 32'd1);
    repeat (4) tick();
    check("cad_e8", 32'(pos_of(0)), 32'd2);
    repeat (116) tick();
    check("cad_31", 32'(pos_of(1)), 32'd31);
    repeat (4) tick();
    check("cad_wrap", 32'(pos_of(1)), 32'd0);
    stop_seq(1'b0, 1'b0);

    // Out-of-range reel write in IDLE
    bus.cfg_we   = 1'b1;
    bus.cfg_reel = 2'd3;
    bus.cfg_addr = 6'd0;
    bus.cfg_data = 5'd9;
    tick();
    bus.cfg_we = 1'b0;
    check("cfg_err_bad_reel", 32'(bus.cfg_err), 32'd1);
    tick();
    check("cfg_err_clear", 32'(bus.cfg_err), 32'd0);

    // Full weighted map load; last write coincides with spin_req
    for (int r = 0; r < NR; r++) begin
      for (int v = 0; v < 64; v++) begin
        map_m[r][v]  = PW'(v * 7 + r * 11 + 3);
        bus.cfg_we   = 1'b1;
        bus.cfg_reel = 2'(r);
        bus.cfg_addr = 6'(v);
        bus.cfg_data = map_m[r][v];
        bus.spin_req = (r == NR - 1) && (v == 63);
        tick();
      end
    end
    bus.cfg_we   = 1'b0;
    bus.spin_req = 1'b0;
    check("load_no_err", 32'(bus.cfg_err), 32'd0);
    check("load_then_spin", 32'(bus.busy), 32'd1);
    repeat (20) tick();
    stop_seq(1'b1, 1'b1);

    // spin_req and stop_req together in IDLE: spin only
    bus.spin_req = 1'b1;
    bus.stop_req = 1'b1;
    tick();
    bus.spin_req = 1'b0;
    bus.stop_req = 1'b0;
    check("both_busy", 32'(bus.busy), 32'd1);
    repeat (20) tick();
    check("both_still_spinning", 32'(bus.reel_stopped), 32'd0);
    stop_seq(1'b0, 1'b0);

    // Reset in STOPPING after reel 0 has stopped
    bus.spin_req = 1'b1;
    tick();
    bus.spin_req = 1'b0;
    repeat (10) tick();
    bus.stop_req = 1'b1;
    tick();
    bus.stop_req = 1'b0;
    repeat (16) tick();
    check("mid_reel0_stopped", 32'(bus.reel_stopped), 32'h1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_stopped", 32'(bus.reel_stopped), 32'h7);
    check("mid_rst_pos", 32'(bus.reel_pos), 32'd0);
    rst_n = 1'b1;
    map_identity();
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);

    // Map restored to identity
    bus.spin_req = 1'b1;
    tick();
    bus.spin_req = 1'b0;
    repeat (20) tick();
    stop_seq(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
